// File: rtl/key_event_if.sv
// key_event_if: one-event-per-handshake valid/ready channel carrying
// key press/release events from key_event_reader to the judging logic.
//   EV_VALID  master->slave  event available
//   EV_READY  slave->master  consumer accepts the event
//   EV_LANE   master->slave  lane index of the event
//   EV_PRESS  master->slave  1 = press, 0 = release
interface key_event_if #(
  parameter int LANES = 4
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic          EV_VALID;
  logic          EV_READY;
  logic [LW-1:0] EV_LANE;
  logic          EV_PRESS;

  modport master (output EV_VALID, output EV_LANE, output EV_PRESS, input EV_READY);
  modport slave  (input EV_VALID, input EV_LANE, input EV_PRESS, output EV_READY);
endinterface

// File: rtl/key_event_reader.sv
// key_event_reader: debounces a registered LANES-bit key vector and turns
// debounced edges into discrete events delivered over key_event_if.
//   C        clock, rising edge
//   INIT_N   asynchronous active-low reset
//   KEY      registered key vector, 1 = pressed
//   STABLE   debounced key state
//   OVF      sticky flag: an event was lost
//   CLR_OVF  synchronous clear of OVF (a new loss on the same edge wins)
//   ev       event channel (master side): EV_VALID/EV_READY/EV_LANE/EV_PRESS
// Build option: define KEY_RELEASE_EVT_EN to report release events too.
// Without it only presses are reported, EV_PRESS is tied to 1, and a press
// hitting an occupied slot keeps the older event and raises OVF.
module key_event_reader #(
  parameter int LANES      = 4,
  parameter int DEB_CYCLES = 16   // legal range 2..255
) (
  input  logic             C,
  input  logic             INIT_N,
  input  logic [LANES-1:0] KEY,
  output logic [LANES-1:0] STABLE,
  output logic             OVF,
  input  logic             CLR_OVF,
  key_event_if.master      ev
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic [7:0]       r_cnt [LANES];
  logic [LANES-1:0] r_stable;
  logic [LANES-1:0] r_pend;      // pending slot valid bits
  logic             r_ev_valid;
  logic [LW-1:0]    r_ev_lane;
  logic             r_ovf;
`ifdef KEY_RELEASE_EVT_EN
  logic [LANES-1:0] r_ptype;     // pending slot type: 1 = press
  logic             r_ev_press;
`endif

  logic [LANES-1:0] w_flip;      // lane's debounced state flips this edge
  logic [LANES-1:0] w_evt;       // flip that produces an event
  logic [LANES-1:0] w_taken;     // slot handed to the output this edge
  logic [LANES-1:0] w_clash;     // new event meets an occupied slot
  logic             w_load;
  logic             w_any;
  logic [LW-1:0]    w_sel;

  assign w_load = !r_ev_valid || ev.EV_READY;

  // Lowest-index pending slot wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_any = 1'b1;
        w_sel = LW'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Counter holds DEB_CYCLES-1 after that many differing edges, so the
      // flip lands on the DEB_CYCLES-th consecutive differing edge.
      assign w_flip[gi]  = (KEY[gi] != r_stable[gi]) && (r_cnt[gi] == CNT_LAST);
`ifdef KEY_RELEASE_EVT_EN
      assign w_evt[gi]   = w_flip[gi];
`else
      assign w_evt[gi]   = w_flip[gi] && !r_stable[gi];   // 0->1 only
`endif
      assign w_taken[gi] = w_load && w_any && (w_sel == LW'(gi));
      // A slot being emptied into the output this edge is free for reuse.
      assign w_clash[gi] = w_evt[gi] && r_pend[gi] && !w_taken[gi];
    end
  endgenerate

  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      for (int i = 0; i < LANES; i++) r_cnt[i] <= '0;
      r_stable   <= '0;
      r_pend     <= '0;
      r_ev_valid <= 1'b0;
      r_ev_lane  <= '0;
      r_ovf      <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
      r_ptype    <= '0;
      r_ev_press <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < LANES; i++) begin
        // Debounce
        if (KEY[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= ~r_stable[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end

        // Pending slot
        if (w_evt[i]) begin
          if (w_clash[i]) begin
`ifdef KEY_RELEASE_EVT_EN
            r_pend[i] <= 1'b0;   // press + release cancel each other
`endif
          end else begin
            r_pend[i] <= 1'b1;
`ifdef KEY_RELEASE_EVT_EN
            r_ptype[i] <= ~r_stable[i];
`endif
          end
        end else if (w_taken[i]) begin
          r_pend[i] <= 1'b0;
        end
      end

      if (|w_clash)     r_ovf <= 1'b1;
      else if (CLR_OVF) r_ovf <= 1'b0;

      if (w_load) begin
        r_ev_valid <= w_any;
        if (w_any) begin
          r_ev_lane <= w_sel;
`ifdef KEY_RELEASE_EVT_EN
          r_ev_press <= r_ptype[w_sel];
`endif
        end
      end
    end
  end

  assign STABLE      = r_stable;
  assign OVF         = r_ovf;
  assign ev.EV_VALID = r_ev_valid;
  assign ev.EV_LANE  = r_ev_lane;
`ifdef KEY_RELEASE_EVT_EN
  assign ev.EV_PRESS = r_ev_press;
`else
  assign ev.EV_PRESS = 1'b1;
`endif
endmodule

// File: tb/tb_key_event_reader.sv
// tb_key_event_reader: directed stimulus against a per-lane event model,
// checked every falling edge, plus hand-computed literal expectations.
module tb_key_event_reader;
  localparam int LANES = 4;
  localparam int DEB   = 16;
`ifdef KEY_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic       C = 1'b0;
  logic       INIT_N;
  logic [3:0] KEY;
  logic [3:0] STABLE;
  logic       OVF;
  logic       CLR_OVF;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  key_event_if #(.LANES(LANES)) ev_if ();

  key_event_reader #(.LANES(LANES), .DEB_CYCLES(DEB)) dut (
    .C(C), .INIT_N(INIT_N), .KEY(KEY), .STABLE(STABLE),
    .OVF(OVF), .CLR_OVF(CLR_OVF), .ev(ev_if)
  );

  always #5 C = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge C);
  endtask

  // ---------------- behavioural model ----------------
  int       m_run [4] = '{0, 0, 0, 0};   // consecutive edges KEY differed
  bit [3:0] m_stable = '0;
  bit       m_pv [4] = '{0, 0, 0, 0};
  bit       m_pt [4] = '{0, 0, 0, 0};
  bit       m_valid = 1'b0;
  int       m_lane = 0;
  bit       m_press = 1'b0;
  bit       m_ovf = 1'b0;

  always @(posedge C or negedge INIT_N) begin : model
    int  taken;
    bit  load;
    bit  lost;
    bit  flip;
    if (!INIT_N) begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
      end
      m_stable = '0; m_valid = 0; m_lane = 0; m_press = 0; m_ovf = 0;
    end else begin
      load  = !m_valid || (ev_if.EV_READY === 1'b1);
      taken = -1;
      for (int i = 3; i >= 0; i--) if (m_pv[i]) taken = i;
      if (load && taken >= 0) m_pv[taken] = 0;
      lost = 0;
      for (int i = 0; i < 4; i++) begin
        if (KEY[i] != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        flip = (m_run[i] == DEB);
        if (flip) begin
          m_run[i] = 0;
          m_stable[i] = ~m_stable[i];
          if (REL_EN || m_stable[i]) begin
            if (m_pv[i]) begin
              lost = 1;
              if (REL_EN) m_pv[i] = 0;
            end else begin
              m_pv[i] = 1;
              m_pt[i] = m_stable[i];
            end
          end
        end
      end
      if (lost) m_ovf = 1;
      else if (CLR_OVF) m_ovf = 0;
      if (load) begin
        m_valid = (taken >= 0);
        if (taken >= 0) begin
          m_lane  = taken;
          m_press = m_pt[taken];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge C) begin
    if (cmp_en) begin
      chk("stable", 32'(STABLE), 32'(m_stable));
      chk("ev_valid", 32'(ev_if.EV_VALID), 32'(m_valid));
      chk("ovf", 32'(OVF), 32'(m_ovf));
      if (m_valid) begin
        chk("ev_lane", 32'(ev_if.EV_LANE), 32'(m_lane));
        chk("ev_press", 32'(ev_if.EV_PRESS), 32'(REL_EN ? m_press : 1'b1));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] key_v;
  int nev;
  int first_lane;
  int hold_bad;
  int seen_valid;

  initial begin
    INIT_N = 1'b0; KEY = 4'b1111; CLR_OVF = 1'b0; ev_if.EV_READY = 1'b1;
    wait_neg(3);
    cmp_en = 1'b1;
    chk("rst_stable", 32'(STABLE), 0);
    chk("rst_valid", 32'(ev_if.EV_VALID), 0);
    chk("rst_ovf", 32'(OVF), 0);
    chk("rst_lane", 32'(ev_if.EV_LANE), 0);
    chk("rst_press", 32'(ev_if.EV_PRESS), 32'(!REL_EN));

    // Press burst: flip on edge 16, events lanes 0..3 on edges 17..20
    INIT_N = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      @(posedge C); #1;
      chk("burst_stable", 32'(STABLE), (e >= 16) ? 32'hF : 32'h0);
      chk("burst_valid", 32'(ev_if.EV_VALID), (e >= 17 && e <= 20) ? 1 : 0);
      if (e >= 17 && e <= 20) begin
        chk("burst_lane", 32'(ev_if.EV_LANE), 32'(e - 17));
        chk("burst_press", 32'(ev_if.EV_PRESS), 1);
      end
    end

    // Bounce rejection from a clean reset
    @(negedge C); #2 INIT_N = 1'b0; KEY = 4'b0000;
    wait_neg(2);
    INIT_N = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 60; c++) begin
      KEY = {1'b0, 1'(((c / 5) % 2)), 2'b00};
      @(negedge C);
      if (ev_if.EV_VALID) seen_valid++;
    end
    chk("bounce_stable", 32'(STABLE), 0);
    chk("bounce_valid_seen", 32'(seen_valid), 0);
    KEY = 4'b0000;
    wait_neg(3);

    // Backpressure on lane 1
    ev_if.EV_READY = 1'b0; KEY = 4'b0010;
    wait_neg(17);
    chk("bp_valid", 32'(ev_if.EV_VALID), 1);
    chk("bp_lane", 32'(ev_if.EV_LANE), 1);
    chk("bp_press", 32'(ev_if.EV_PRESS), 1);
    hold_bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge C);
      if (!(ev_if.EV_VALID && ev_if.EV_LANE == 2'd1 && ev_if.EV_PRESS)) hold_bad++;
    end
    chk("bp_hold", 32'(hold_bad), 0);
    ev_if.EV_READY = 1'b1;
    @(posedge C); #1;
    chk("bp_accept_valid", 32'(ev_if.EV_VALID), 0);
    @(negedge C);
    KEY = 4'b0000;               // release lane 1, drain anything it produces
    wait_neg(20);

    // Overflow / cancel
    ev_if.EV_READY = 1'b0; KEY = 4'b0001;
    wait_neg(17);
    chk("ovf_lane0_out", 32'(ev_if.EV_LANE), 0);
    KEY = 4'b1001;
    wait_neg(16);
    KEY = 4'b0001;
    wait_neg(16);
    chk("ovf_after_release", 32'(OVF), 32'(REL_EN));
`ifndef KEY_RELEASE_EVT_EN
    KEY = 4'b1001;               // second press onto the still-occupied slot
    wait_neg(16);
    chk("ovf_after_repress", 32'(OVF), 1);
`endif
    ev_if.EV_READY = 1'b1;
    nev = 0; first_lane = -1;
    for (int k = 0; k < 5; k++) begin
      if (ev_if.EV_VALID) begin
        if (nev == 0) first_lane = int'(ev_if.EV_LANE);
        nev++;
      end
      @(negedge C);
    end
    chk("drain_count", 32'(nev), REL_EN ? 1 : 2);
    chk("drain_first_lane", 32'(first_lane), 0);

    // OVF clear with no new loss
    CLR_OVF = 1'b1;
    @(posedge C); #1;
    chk("ovf_clear", 32'(OVF), 0);
    @(negedge C); CLR_OVF = 1'b0;

    // OVF clear coinciding with a new loss
    key_v = KEY;
    ev_if.EV_READY = 1'b0;
    key_v[2] = 1'b1; KEY = key_v;
    wait_neg(17);
    key_v[1] = 1'b1; KEY = key_v;
    wait_neg(16);
    key_v[1] = 1'b0; KEY = key_v;
`ifndef KEY_RELEASE_EVT_EN
    wait_neg(16);
    key_v[1] = 1'b1; KEY = key_v;
`endif
    wait_neg(15);
    chk("ovf_before_loss", 32'(OVF), 0);
    CLR_OVF = 1'b1;
    @(posedge C); #1;
    chk("ovf_set_beats_clr", 32'(OVF), 1);
    @(negedge C); CLR_OVF = 1'b0;

    // Asynchronous reset mid-transfer
    chk("pre_rst_valid", 32'(ev_if.EV_VALID), 1);
    @(negedge C); #2 INIT_N = 1'b0;
    #1;
    chk("async_valid", 32'(ev_if.EV_VALID), 0);
    chk("async_stable", 32'(STABLE), 0);
    chk("async_ovf", 32'(OVF), 0);
    wait_neg(2);
    INIT_N = 1'b1;
    wait_neg(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
